// File: rtl/uart_rx.sv
// uart_rx: 8x-oversampled UART receiver. 8 data bits LSB first, optional
// even/odd parity, one stop bit. Each bit is a 3-sample majority vote taken
// at sub-ticks 3, 4 and 5. Bytes leave on a valid/ready handshake together
// with their frame and parity error flags.
module uart_rx (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_8,
    input  logic       rxd,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Two or more ones out of three samples gives a one.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Nonzero when data, received parity bit and the odd/even selector disagree.
    function automatic logic parity_mismatch(input logic [7:0] d, input logic p, input logic odd);
        return ^{d, p, odd};
    endfunction

    logic       sync_meta_r;
    logic       rxs_r;
    state_t     state_r;
    state_t     state_next_s;
    logic [2:0] sub_r;
    logic [2:0] bit_idx_r;
    logic [7:0] shift_r;
    logic [1:0] samp_r;
    logic       samp5_r;
    logic       par_en_r;
    logic       par_odd_r;
    logic       par_err_frame_r;
    logic       start_s;
    logic       shift_en_s;
    logic       par_chk_s;
    logic       complete_s;
    logic       vote_mid_s;
    logic       vote_stop_s;
    logic       out_valid_r;
    logic [7:0] out_data_r;
    logic       frame_err_r;
    logic       parity_err_r;
    logic       overrun_r;
    logic       busy_r;

    // Vote at sub 7 uses all three stored samples; the stop vote is taken at
    // sub 5 itself, so the third sample is the live synchronized line.
    assign vote_mid_s  = majority3(samp_r[0], samp_r[1], samp5_r);
    assign vote_stop_s = majority3(samp_r[0], samp_r[1], rxs_r);

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

    // Two-flop synchronizer for the asynchronous serial line, idle high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta_r <= 1'b1;
            rxs_r       <= 1'b1;
        end else begin
            sync_meta_r <= rxd;
            rxs_r       <= sync_meta_r;
        end
    end

    // Next-state logic and per-tick action strobes; nothing moves without ce_8.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        shift_en_s   = 1'b0;
        par_chk_s    = 1'b0;
        complete_s   = 1'b0;
        if (ce_8) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxs_r) begin
                        state_next_s = ST_START;
                        start_s      = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (sub_r == 3'd7) begin
                        if (vote_mid_s) begin
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_DATA;
                        end
                    end else begin
                        state_next_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (sub_r == 3'd7) begin
                        shift_en_s = 1'b1;
                        if (bit_idx_r == 3'd7) begin
                            if (par_en_r) begin
                                state_next_s = ST_PARITY;
                            end else begin
                                state_next_s = ST_STOP;
                            end
                        end else begin
                            state_next_s = ST_DATA;
                        end
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (sub_r == 3'd7) begin
                        par_chk_s    = 1'b1;
                        state_next_s = ST_STOP;
                    end else begin
                        state_next_s = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    // Decide early at sub 5 so a back-to-back start edge is caught.
                    if (sub_r == 3'd5) begin
                        complete_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_STOP;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sub-tick counter: the detecting tick is sub 0, STOP exits at sub 5.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sub_r <= 3'd0;
        end else if (ce_8) begin
            if (state_r == ST_IDLE) begin
                sub_r <= start_s ? 3'd1 : 3'd0;
            end else if (complete_s) begin
                sub_r <= 3'd0;
            end else begin
                sub_r <= sub_r + 3'd1;
            end
        end
    end

    // Capture the line at sub 3, 4 and 5 for the majority vote.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp_r  <= 2'b11;
            samp5_r <= 1'b1;
        end else if (ce_8) begin
            if (sub_r == 3'd3) begin
                samp_r[0] <= rxs_r;
            end
            if (sub_r == 3'd4) begin
                samp_r[1] <= rxs_r;
            end
            if (sub_r == 3'd5) begin
                samp5_r <= rxs_r;
            end
        end
    end

    // Frame datapath: config latched at start, data bits and parity result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_idx_r       <= 3'd0;
            shift_r         <= 8'h00;
            par_en_r        <= 1'b0;
            par_odd_r       <= 1'b0;
            par_err_frame_r <= 1'b0;
        end else begin
            if (start_s) begin
                bit_idx_r       <= 3'd0;
                par_en_r        <= parity_en;
                par_odd_r       <= parity_odd;
                par_err_frame_r <= 1'b0;
            end
            if (shift_en_s) begin
                shift_r[bit_idx_r] <= vote_mid_s;
                bit_idx_r          <= bit_idx_r + 3'd1;
            end
            if (par_chk_s) begin
                par_err_frame_r <= parity_mismatch(shift_r, vote_mid_s, par_odd_r);
            end
        end
    end

    // Output register: frame delivery, overrun drop and handshake clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'h00;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (complete_s) begin
                if (out_valid_r && !out_ready) begin
                    overrun_r <= 1'b1;
                end else begin
                    overrun_r    <= 1'b0;
                    out_valid_r  <= 1'b1;
                    out_data_r   <= shift_r;
                    frame_err_r  <= !vote_stop_s;
                    parity_err_r <= par_err_frame_r;
                end
            end else begin
                overrun_r <= 1'b0;
                if (out_valid_r && out_ready) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. A byte-level model tracks the
// pending output; a per-cycle compare process checks it while the line is idle.
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce_8 = 1'b0;
    logic       rxd = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int ovr_cycles = 0;
    logic checking = 1'b0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_perr = 1'b0;

    uart_rx dut (
        .clock      (clock),
        .reset      (reset),
        .ce_8       (ce_8),
        .rxd        (rxd),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial forever #5 clock = ~clock;

    // ce_8 once every 4 clocks, driven away from the active edge
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clock);
            cnt = (cnt + 1) % 4;
            ce_8 = (cnt == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // return 1 time unit after a clock edge that consumed a ce_8 strobe
    task automatic tick();
        @(posedge clock);
        while (!ce_8) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // send one frame aligned to ce_8 ticks, then update the model
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_b);
        int ones;
        logic perr;
        checking = 1'b0;
        rxd = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (8) tick();
        end
        if (parity_en) begin
            rxd = pbit;
            repeat (8) tick();
        end
        rxd = stop_b;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) begin
                chk("stop_busy_pre", busy, 1);
                if (!m_valid) chk("stop_valid_pre", out_valid, 0);
            end
            if (i == 6) begin
                chk("stop_busy_fall", busy, 0);
                chk("stop_valid_rise", out_valid, 1);
                rxd = 1'b1;
            end
        end
        ones = $countones({d, pbit});
        if (!parity_en) perr = 1'b0;
        else if (parity_odd) perr = (ones % 2 == 0);
        else perr = (ones % 2 == 1);
        if (!m_valid) begin
            m_data = d;
            m_ferr = !stop_b;
            m_perr = perr;
            m_valid = 1'b1;
        end
        checking = 1'b1;
    endtask

    task automatic accept();
        @(negedge clock);
        out_ready = 1'b1;
        m_valid = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        chk("accept_clear", out_valid, 0);
    endtask

    // per-cycle comparison against the model while the line is quiet
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (checking) begin
                chk("cmp_valid", out_valid, m_valid);
                chk("cmp_busy", busy, 0);
                chk("cmp_overrun", overrun, 0);
                if (m_valid) begin
                    chk("cmp_data", out_data, m_data);
                    chk("cmp_ferr", frame_err, m_ferr);
                    chk("cmp_perr", parity_err, m_perr);
                end
            end
        end
    end

    // count cycles with overrun high
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (overrun) ovr_cycles++;
        end
    end

    initial begin
        logic [7:0] part;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        checking = 1'b1;
        idle(4);

        // basic receive
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(3);
        chk("t1_data", out_data, 8'hA5);
        chk("t1_ferr", frame_err, 0);
        chk("t1_perr", parity_err, 0);
        accept();
        idle(2);

        // glitch rejection
        checking = 1'b0;
        rxd = 1'b0;
        repeat (2) tick();
        chk("t2_busy_up", busy, 1);
        rxd = 1'b1;
        repeat (5) tick();
        chk("t2_busy_sub6", busy, 1);
        tick();
        chk("t2_busy_sub7", busy, 0);
        chk("t2_no_valid", out_valid, 0);
        checking = 1'b1;
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("t2_data", out_data, 8'h3C);
        accept();

        // parity
        parity_en = 1'b1;
        parity_odd = 1'b0;
        idle(2);
        send_frame(8'h37, 1'b1, 1'b1);
        chk("t3a_perr", parity_err, 0);
        accept();
        send_frame(8'h37, 1'b0, 1'b1);
        chk("t3b_data", out_data, 8'h37);
        chk("t3b_perr", parity_err, 1);
        accept();
        parity_odd = 1'b1;
        idle(2);
        send_frame(8'h37, 1'b0, 1'b1);
        chk("t3c_perr", parity_err, 0);
        accept();
        parity_en = 1'b0;
        parity_odd = 1'b0;
        idle(2);

        // framing error
        send_frame(8'h55, 1'b0, 1'b0);
        chk("t4_data", out_data, 8'h55);
        chk("t4_ferr", frame_err, 1);
        chk("t4_valid", out_valid, 1);
        accept();
        idle(2);

        // overrun
        ovr_cycles = 0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle(2);
        chk("t5_ovr_cycles", ovr_cycles, 1);
        chk("t5_data_kept", out_data, 8'h11);
        accept();
        send_frame(8'h33, 1'b0, 1'b1);
        chk("t5_data_next", out_data, 8'h33);

        // reset during data bit 4 while a byte is still pending
        checking = 1'b0;
        part = 8'h5A;
        rxd = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            rxd = part[i];
            repeat (8) tick();
        end
        rxd = part[4];
        repeat (3) tick();
        chk("t6_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_data", out_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ferr", frame_err, 0);
        chk("t6_perr", parity_err, 0);
        rxd = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_valid = 1'b0;
        m_data = 8'h00;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        checking = 1'b1;
        idle(4);
        send_frame(8'hC3, 1'b0, 1'b1);
        chk("t6_data_after", out_data, 8'hC3);
        accept();
        idle(2);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage that consumes the `ce_8` oversampling strobe from the baud generator and recovers bytes from the serial line. It sits between the pad-side `rxd` input and the byte-level consumer (FIFO or register interface).
- Format: 8 data bits, LSB first, optional even/odd parity, one stop bit.
- Each bit is sampled 8 times with a 3-sample majority vote.
- Bytes are delivered on a valid/ready handshake with per-byte error flags.

## Interface
Parameters:
- none (frame width fixed at 8 data bits; oversampling fixed at 8).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `ce_8`  in  1  single-cycle oversampling strobe from the baud generator (8 per bit period).
- `rxd`  in  1  raw serial input, asynchronous to `clock`, idle high.
- `parity_en`  in  1  1 = a parity bit follows the data bits.
- `parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_valid`  out  1  received byte available.
- `out_data`  out  8  received byte.
- `frame_err`  out  1  stop bit of `out_data` sampled low.
- `parity_err`  out  1  parity mismatch for `out_data`; always 0 when parity was disabled.
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped because `out_valid` was still pending.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized `rxs`.
- **Sub-tick counter:** 3-bit `sub` advances only on `ce_8`. It wraps 7 -> 0, and each wrap advances to the next bit.
- **Majority vote:** per bit, the values of `rxs` at `ce_8` with `sub` = 3, 4 and 5. Two or more ones gives 1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - On `ce_8` with `rxs`=0, go to START with `sub`=1. The detecting tick counts as sub 0.
  - Latch `parity_en` and `parity_odd` at this point; they are held for the whole frame.
- **START:**
  - At `ce_8` with `sub`=7: if the vote is 1, treat it as a false start and return to IDLE with no output.
  - Otherwise go to DATA with bit index 0.
- **DATA:**
  - At `sub`=7, shift the vote into bit[index] (LSB first) and increment the index.
  - After index 7, go to PARITY if the latched `parity_en` is set, else to STOP.
- **PARITY:**
  - At `sub`=7, compute err = (XOR of data ^ vote ^ latched `parity_odd`) != 0, then go to STOP.
- **STOP:**
  - The decision is taken at `ce_8` with `sub`=5, not 7, so the next start edge can be caught. The vote uses samples 3, 4 and 5.
  - Then return to IDLE and complete the frame.
- **Frame completion:**
  - If `out_valid`=1 and `out_ready`=0 in that cycle: pulse `overrun` for one cycle and drop the new byte. `out_data` and the flags keep their old values.
  - Otherwise load `out_data`, set `frame_err` = !vote, load `parity_err`, and set `out_valid`=1.
- **Handshake:**
  - `out_valid` clears on the cycle after `out_valid && out_ready`, unless a new frame completes in that same cycle, in which case it stays 1 with the new data.
  - `out_data` and the flags are stable while `out_valid`=1.
- **Status flags:** error flags are data-qualified status, not sticky. They are only meaningful while `out_valid`=1.

## Timing
- **Reset values:**
  - `out_valid`, `out_data`, `frame_err`, `parity_err`, `overrun` and `busy` are all 0.
  - The FSM is in IDLE and `sub`=0.
- **Reset mid-frame:** abort immediately with the values above. The next falling edge starts a clean frame.
- **Input latency:** a `rxd` edge is visible to the FSM 2 clocks later.
- **Output latency:** `out_valid` rises one clock after the STOP `ce_8` at `sub`=5. That is about 8×(9 + parity_en) + 5 `ce_8` ticks after the start tick.
- **Strobe rate:** `ce_8` may be asserted every clock. Nothing advances without `ce_8`.
- **`busy`:** rises the clock after start detection and falls the clock after the STOP decision or a false start.
- **Config changes mid-frame:** changes to `parity_en`/`parity_odd` have no effect until the next start detection.

## Test plan
1. **Basic receive:** `ce_8` every 4 clocks, send 0xA5 with no parity and a good stop bit.
   - `out_data`=0xA5, `out_valid`=1, `frame_err`=0, `parity_err`=0.
   - `out_ready` pulse -> `out_valid`=0 the next cycle.
2. **Glitch rejection:** `rxd` low for 2 ticks, then high.
   - `busy` returns to 0 at START `sub`=7.
   - No `out_valid`; the following 0x3C frame is received correctly.
3. **Parity:** `parity_en`=1, `parity_odd`=0.
   - 0x37 with parity bit 1 -> `parity_err`=0.
   - 0x37 with parity bit 0 -> `out_data`=0x37, `parity_err`=1.
   - With `parity_odd`=1 and parity bit 0 -> `parity_err`=0.
4. **Framing error:** 0x55 with stop bit 0.
   - `out_data`=0x55, `frame_err`=1, `out_valid`=1.
5. **Overrun:** send 0x11 then 0x22 back-to-back with `out_ready`=0.
   - One-cycle `overrun` pulse at the end of the second frame; `out_data` stays 0x11.
   - After acceptance, 0x33 is received normally.
6. **Reset mid-frame:** assert `reset` during DATA bit 4.
   - All outputs go to 0 and the FSM returns to IDLE.
   - After release, 0xC3 is received correctly.
